// File: rtl/sseg_pkg.sv
// sseg_pkg: shared segment type, hex font table and blank constant for the seven-segment scanner.
package sseg_pkg;
   typedef logic [6:0] seg_t;
   localparam seg_t SEG_BLANK = 7'h7F;
   // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
   localparam seg_t HEX_FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
endpackage

// File: rtl/sseg_scan_ctl_if.sv
// sseg_scan_ctl_if: display data inputs and multiplexed segment/anode outputs of the scanner.
interface sseg_scan_ctl_if #(parameter int N_DIGITS = 4);
   import sseg_pkg::*;
   logic [4*N_DIGITS-1:0] digits;
   logic [N_DIGITS-1:0] dp;
   logic blank_lz;
   logic [3:0] brightness;
   seg_t seg_n;
   logic dp_n;
   logic [N_DIGITS-1:0] an_n;
   modport master (output digits, dp, blank_lz, brightness, input seg_n, dp_n, an_n);
   modport slave (input digits, dp, blank_lz, brightness, output seg_n, dp_n, an_n);
endinterface

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational hex nibble to active-low segment pattern.
module sseg_hex_decode
   import sseg_pkg::*;
(
   input  logic [3:0] nib_i,
   output seg_t       seg_n_o
);
   assign seg_n_o = HEX_FONT[nib_i];
endmodule

// File: rtl/sseg_scan_ctl.sv
// sseg_scan_ctl: multiplexed seven-segment scanner with leading-zero blanking and registered outputs.
// Optional PWM dimming is built in when SSEG_SCAN_DIMMING_EN is defined.
module sseg_scan_ctl
   import sseg_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int REFRESH_CYCLES = 100000
) (
   input logic clk,
   input logic rst,
   sseg_scan_ctl_if.slave bus
);
   localparam int PW = $clog2(REFRESH_CYCLES);
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
   logic [PW-1:0] presc_q, presc_d;
   logic [IW-1:0] idx_q, idx_d;
   seg_t seg_n_q, seg_n_d, font_n;
   logic dp_n_q, dp_n_d;
   logic [N_DIGITS-1:0] an_n_q, an_n_d, lz, sel;
   logic wrap, blank, on;
   sseg_hex_decode u_dec (.nib_i(bus.digits[{idx_q, 2'b00} +: 4]), .seg_n_o(font_n));
   // lz[i] is set when digit i and every digit above it are zero.
   always_comb begin
      logic z;
      z = 1'b1;
      lz = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         z = z && bus.digits[4*i +: 4] == 4'h0;
         lz[i] = z;
      end
   end
`ifdef SSEG_SCAN_DIMMING_EN
   logic [3:0] pwm_q, bright_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_q <= '0;
         bright_q <= 4'hF;
      end else begin
         pwm_q <= pwm_q + 1'b1;
         bright_q <= wrap ? bus.brightness : bright_q;
      end
   end
   assign on = pwm_q <= bright_q;
`else
   logic unused_brightness;
   assign unused_brightness = ^bus.brightness;
   assign on = 1'b1;
`endif
   always_comb begin
      wrap = presc_q == PW'(REFRESH_CYCLES - 1);
      presc_d = wrap ? '0 : presc_q + 1'b1;
      idx_d = !wrap ? idx_q : idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1;
      blank = bus.blank_lz && idx_q != '0 && lz[idx_q];
      sel = N_DIGITS'(1) << idx_q;
      an_n_d = blank || !on ? '1 : ~sel;
      seg_n_d = blank ? SEG_BLANK : font_n;
      dp_n_d = blank || !bus.dp[idx_q];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         idx_q <= '0;
         seg_n_q <= SEG_BLANK;
         dp_n_q <= 1'b1;
         an_n_q <= '1;
      end else begin
         presc_q <= presc_d;
         idx_q <= idx_d;
         seg_n_q <= seg_n_d;
         dp_n_q <= dp_n_d;
         an_n_q <= an_n_d;
      end
   end
   assign bus.seg_n = seg_n_q;
   assign bus.dp_n = dp_n_q;
   assign bus.an_n = an_n_q;
endmodule

// File: tb/tb_sseg_scan_ctl.sv
// tb_sseg_scan_ctl: directed vector bench for sseg_scan_ctl (N_DIGITS=4, REFRESH_CYCLES=4), either dimming build.
module tb_sseg_scan_ctl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int lit = 0;
   logic exp_on;
   logic [6:0] exp_seg;
   logic [3:0] exp_an;
   logic [6:0] fnt [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
   sseg_scan_ctl_if #(.N_DIGITS(4)) bus ();
   sseg_scan_ctl #(.N_DIGITS(4), .REFRESH_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic        blank_lz;
      logic [6:0]  seg;
      logic        dp_n;
      logic [3:0]  an;
   } vec_t;
   vec_t tbl [24];
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask
   task automatic check(string name, logic [6:0] seg, logic dpn, logic [3:0] an);
      n_chk++;
      if ({bus.seg_n, bus.dp_n, bus.an_n} !== {seg, dpn, an}) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got seg_n=%h dp_n=%b an_n=%b, expected seg_n=%h dp_n=%b an_n=%b",
                  name, cyc, bus.seg_n, bus.dp_n, bus.an_n, seg, dpn, an);
      end
   endtask
   task automatic drive(logic [15:0] d, logic [3:0] p, logic b, logic [3:0] br);
      bus.digits = d;
      bus.dp = p;
      bus.blank_lz = b;
      bus.brightness = br;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end
   initial begin
      tbl[0]  = '{16'h1234, 4'h0, 1'b0, 7'h19, 1'b1, 4'hE};
      tbl[1]  = '{16'h1234, 4'h0, 1'b0, 7'h30, 1'b1, 4'hD};
      tbl[2]  = '{16'h1234, 4'h0, 1'b0, 7'h24, 1'b1, 4'hB};
      tbl[3]  = '{16'h1234, 4'h0, 1'b0, 7'h79, 1'b1, 4'h7};
      tbl[4]  = '{16'h0050, 4'h0, 1'b1, 7'h40, 1'b1, 4'hE};
      tbl[5]  = '{16'h0050, 4'h0, 1'b1, 7'h12, 1'b1, 4'hD};
      tbl[6]  = '{16'h0050, 4'h0, 1'b1, 7'h7F, 1'b1, 4'hF};
      tbl[7]  = '{16'h0050, 4'h0, 1'b1, 7'h7F, 1'b1, 4'hF};
      tbl[8]  = '{16'h0000, 4'h0, 1'b1, 7'h40, 1'b1, 4'hE};
      tbl[9]  = '{16'h0000, 4'h0, 1'b1, 7'h7F, 1'b1, 4'hF};
      tbl[10] = '{16'h0000, 4'h0, 1'b1, 7'h7F, 1'b1, 4'hF};
      tbl[11] = '{16'h0000, 4'h0, 1'b1, 7'h7F, 1'b1, 4'hF};
      tbl[12] = '{16'h89AB, 4'h4, 1'b0, 7'h03, 1'b1, 4'hE};
      tbl[13] = '{16'h89AB, 4'h4, 1'b0, 7'h08, 1'b1, 4'hD};
      tbl[14] = '{16'h89AB, 4'h4, 1'b0, 7'h10, 1'b0, 4'hB};
      tbl[15] = '{16'h89AB, 4'h4, 1'b0, 7'h00, 1'b1, 4'h7};
      tbl[16] = '{16'hCDEF, 4'h0, 1'b0, 7'h0E, 1'b1, 4'hE};
      tbl[17] = '{16'hCDEF, 4'h0, 1'b0, 7'h06, 1'b1, 4'hD};
      tbl[18] = '{16'hCDEF, 4'h0, 1'b0, 7'h21, 1'b1, 4'hB};
      tbl[19] = '{16'hCDEF, 4'h0, 1'b0, 7'h46, 1'b1, 4'h7};
      tbl[20] = '{16'h7600, 4'h0, 1'b1, 7'h40, 1'b1, 4'hE};
      tbl[21] = '{16'h7600, 4'h0, 1'b1, 7'h40, 1'b1, 4'hD};
      tbl[22] = '{16'h7600, 4'h0, 1'b1, 7'h02, 1'b1, 4'hB};
      tbl[23] = '{16'h7600, 4'h0, 1'b1, 7'h78, 1'b1, 4'h7};
      drive(16'h1234, 4'h0, 1'b0, 4'hF);
      step();
      step();
      check("reset", 7'h7F, 1'b1, 4'hF);
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].digits, tbl[i].dp, tbl[i].blank_lz, 4'hF);
         for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("vec%0d", i), tbl[i].seg, tbl[i].dp_n, tbl[i].an);
         end
      end
      drive(16'h1234, 4'h0, 1'b0, 4'hF);
      step();
      check("live_before", 7'h19, 1'b1, 4'hE);
      bus.digits = 16'h1238;
      step();
      check("live_after", 7'h00, 1'b1, 4'hE);
      step();
      step();
      step();
      check("live_slot1", 7'h30, 1'b1, 4'hD);
      drive(16'h0008, 4'h0, 1'b1, 4'hF);
      step();
      check("live_blank", 7'h7F, 1'b1, 4'hF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      cyc = 0;
`ifdef SSEG_SCAN_DIMMING_EN
      drive(16'h1234, 4'h0, 1'b0, 4'h3);
`else
      drive(16'h1234, 4'h0, 1'b0, 4'h0);
`endif
      for (int k = 1; k <= 48; k++) begin
         step();
`ifdef SSEG_SCAN_DIMMING_EN
         exp_on = k <= 4 || k > 40 || ((k - 1) % 16) <= 3;
`else
         exp_on = 1'b1;
`endif
         exp_an = exp_on ? ~(4'b0001 << (((k - 1) / 4) % 4)) : 4'hF;
         exp_seg = fnt[((k - 1) / 4) % 4];
         check($sformatf("dim%0d", k), exp_seg, 1'b1, exp_an);
         if (k >= 17 && k <= 32 && bus.an_n != 4'hF) lit++;
         if (k == 37) bus.brightness = 4'hF;
      end
      n_chk++;
`ifdef SSEG_SCAN_DIMMING_EN
      if (lit != 4) begin
         n_fail++;
         $display("FAIL duty: got %0d lit cycles of 16, expected 4", lit);
      end
`else
      if (lit != 16) begin
         n_fail++;
         $display("FAIL duty: got %0d lit cycles of 16, expected 16", lit);
      end
`endif
      for (int k = 49; k <= 58; k++) step();
      rst = 1'b1;
      step();
      check("rst_mid", 7'h7F, 1'b1, 4'hF);
      rst = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("restart%0d", k), 7'h19, 1'b1, 4'hE);
      end
      step();
      check("restart_next", 7'h30, 1'b1, 4'hD);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sseg_scan_ctl.md
SSEG_SCAN_CTL -- requirements
Module: sseg_scan_ctl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 100000, clk cycles per digit slot, legal range >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port digits  input  4*N_DIGITS  hex nibbles; digit i = digits[4i+3:4i], digit 0 rightmost.
REQ-006 SHALL have port dp  input  N_DIGITS  decimal point request per digit, active-high.
REQ-007 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-008 SHALL have port brightness  input  4  dimming level, 15 = full on.
REQ-009 SHALL have port seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp_n  output  1  decimal point segment, active-low.
REQ-011 SHALL have port an_n  output  N_DIGITS  digit anodes, active-low, at most one low at any time.

Function
REQ-012 SHALL keep a prescaler counting 0..REFRESH_CYCLES-1; at REFRESH_CYCLES-1 it wraps to 0 and digit index advances.
REQ-013 SHALL advance digit index 0,1,..,N_DIGITS-1 then wrap to 0; N_DIGITS=1 keeps index at 0.
REQ-014 SHALL decode the selected nibble to segments: standard hex font 0-9, A, b, C, d, E, F.
REQ-015 SHALL drive dp_n = ~dp[index] for the selected digit.
REQ-016 SHALL, when blank_lz=1, blank digit i>0 if digit i and every higher digit equal 0; digit 0 never blanked.
REQ-017 SHALL implement blanking by holding every an_n bit high for the slot; seg_n/dp_n are don't-care but driven all-high.
REQ-018 SHALL register all outputs; outputs reflect index/inputs sampled on the previous clk edge (latency 1).
REQ-019 SHALL sample brightness only when the prescaler wraps; the sampled value holds for the whole next slot.
REQ-020 SHALL, with dimming active, assert the selected anode only when a free-running 4-bit pwm counter <= sampled brightness (brightness 15 = 100%, 0 = 1/16 duty).
REQ-021 SHALL sample digits, dp and blank_lz every cycle (no slot latching), so value changes appear on the next cycle.

Reset
REQ-022 SHALL during rst clear prescaler, digit index and pwm counter to 0, and load sampled brightness with 15.
REQ-023 SHALL during rst and the first cycle after drive seg_n=7'h7F, dp_n=1, an_n all ones.
REQ-024 SHALL, on rst asserted mid-slot, abort the slot; scanning restarts at digit 0 with a full slot.

Configuration
REQ-025 SHALL gate dimming with macro SSEG_SCAN_DIMMING_EN.
REQ-026 SHALL, with SSEG_SCAN_DIMMING_EN defined, implement REQ-019/REQ-020.
REQ-027 SHALL, without SSEG_SCAN_DIMMING_EN, omit the pwm counter and brightness register, ignore brightness, and keep the selected anode on for the full slot.

Structure
REQ-028 SHALL place in package sseg_pkg: 7-bit segment typedef, 16-entry hex-to-segment constant table, SEG_BLANK constant (7'h7F).
REQ-029 SHALL instantiate sub-module sseg_hex_decode (combinational nibble -> active-low segments, via sseg_pkg table).
REQ-030 SHALL size prescaler width as $clog2(REFRESH_CYCLES) and index width as max(1,$clog2(N_DIGITS)).

Verification (N_DIGITS=4, REFRESH_CYCLES=4, dimming enabled unless stated)
REQ-031 SHALL check: digits=16'h1234, blank_lz=0, brightness=15 -> an_n cycles 1110,1101,1011,0111 every 4 clk; seg_n = font of 4,3,2,1.
REQ-032 SHALL check: digits=16'h0050, blank_lz=1 -> digits 3 and 2 an_n all ones in their slots; digit 1 shows 5, digit 0 shows 0.
REQ-033 SHALL check: digits=16'h0000, blank_lz=1 -> only digit 0 lit, showing 0.
REQ-034 SHALL check: brightness=3 -> selected anode low only where pwm counter in 0..3 (4 of every 16 cycles); brightness change mid-slot takes effect next slot.
REQ-035 SHALL check: rst asserted during digit 2 slot -> next cycle all outputs blank; after release digit 0 lit for full 4 cycles.
REQ-036 SHALL check: build without SSEG_SCAN_DIMMING_EN, brightness=0 -> anodes fully on every slot; dp=4'b0100 -> dp_n low only in digit 2 slot.
